// File: rtl/mem_burst_controller_if.sv
// Bus bundle between the miss handler, external memory and the block dispatcher.
// The controller uses the master modport; the surrounding environment uses slave.
interface mem_burst_controller_if #(
  parameter int ADDR_WIDTH      = 8,
  parameter int MEM_DATA_WIDTH  = 32,
  parameter int WORDS_PER_BLOCK = 10
);
  localparam int OFS_W = $clog2(WORDS_PER_BLOCK);

  logic                                  i_halt;
  logic [ADDR_WIDTH-1:0]                 i_req_addr;
  logic [OFS_W-1:0]                      i_req_ofs;
  logic                                  i_req_valid;
  logic                                  o_req_ready;
  logic [ADDR_WIDTH-1:0]                 o_mem_req_addr;
  logic [OFS_W-1:0]                      o_mem_req_ofs;
  logic                                  o_mem_req_valid;
  logic                                  i_mem_req_ready;
  logic [MEM_DATA_WIDTH-1:0]             i_mem_data;
  logic                                  i_mem_data_valid;
  logic                                  o_mem_ready;
  logic [MEM_DATA_WIDTH-1:0]             o_crit_word;
  logic                                  o_crit_word_valid;
  logic [MEM_DATA_WIDTH*WORDS_PER_BLOCK-1:0] o_block_data;
  logic [ADDR_WIDTH-1:0]                 o_block_addr;
  logic                                  o_block_data_valid;
  logic                                  o_error;

  modport master (
    input  i_halt, i_req_addr, i_req_ofs, i_req_valid, i_mem_req_ready, i_mem_data, i_mem_data_valid,
    output o_req_ready, o_mem_req_addr, o_mem_req_ofs, o_mem_req_valid, o_mem_ready,
           o_crit_word, o_crit_word_valid, o_block_data, o_block_addr, o_block_data_valid, o_error
  );

  modport slave (
    output i_halt, i_req_addr, i_req_ofs, i_req_valid, i_mem_req_ready, i_mem_data, i_mem_data_valid,
    input  o_req_ready, o_mem_req_addr, o_mem_req_ofs, o_mem_req_valid, o_mem_ready,
           o_crit_word, o_crit_word_valid, o_block_data, o_block_addr, o_block_data_valid, o_error
  );
endinterface

// File: rtl/mem_burst_controller.sv
// Block-fill controller: one memory request per miss, critical-word-first burst
// with wrap-around assembly, timeout-driven re-issue and error after retry budget.

module mbc_slot #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          we,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  always_ff @(posedge clk) begin
    if (!arst_n)  q <= '0;
    else if (we)  q <= d;
  end
endmodule

module mem_burst_controller #(
  parameter int ADDR_WIDTH      = 8,
  parameter int MEM_DATA_WIDTH  = 32,
  parameter int WORDS_PER_BLOCK = 10,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int MAX_RETRIES     = 3,
  localparam int OFS_W          = $clog2(WORDS_PER_BLOCK)
) (
  input logic                    clk,
  input logic                    arst_n,
  mem_burst_controller_if.master bus
);
  localparam int W  = WORDS_PER_BLOCK;
  localparam int DW = MEM_DATA_WIDTH;
  localparam int CW = $clog2(WORDS_PER_BLOCK + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int IW = OFS_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RECV, S_DONE} state_t;

  state_t                 state, state_n;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [OFS_W-1:0]       ofs_q, slot_idx, slot_sel, slot_nxt;
  logic [IW-1:0]          idx_inc;
  logic [CW-1:0]          cnt;
  logic [TW-1:0]          timer;
  logic [RW-1:0]          retry;
  logic [DW-1:0]          crit_q;
  logic                   crit_pulse, err_pulse;
  logic                   req_fire, mreq_fire, beat_fire, tmo_hit, last_beat;
  logic [W-1:0]           slot_we;
  logic [W-1:0][DW-1:0]   slot_q;

  assign bus.o_req_ready        = (state == S_IDLE) && !bus.i_halt;
  assign bus.o_mem_req_valid    = (state == S_REQ);
  assign bus.o_mem_req_addr     = addr_q;
  assign bus.o_mem_req_ofs      = ofs_q;
  assign bus.o_mem_ready        = ((state == S_WAIT) || (state == S_RECV)) && !bus.i_halt;
  assign bus.o_crit_word        = crit_q;
  assign bus.o_crit_word_valid  = crit_pulse && !bus.i_halt;
  assign bus.o_error            = err_pulse && !bus.i_halt;
  assign bus.o_block_data_valid = (state == S_DONE) && !bus.i_halt;
  assign bus.o_block_addr       = addr_q;
  assign bus.o_block_data       = slot_q;

  assign req_fire  = bus.i_req_valid && bus.o_req_ready;
  assign mreq_fire = bus.o_mem_req_valid && bus.i_mem_req_ready && !bus.i_halt;
  assign beat_fire = bus.i_mem_data_valid && bus.o_mem_ready;
  // a beat landing on the timeout cycle takes priority over the retry
  assign tmo_hit   = (state == S_WAIT) && (timer == TW'(TIMEOUT_CYCLES - 1)) && !beat_fire;
  assign last_beat = (cnt == CW'(W - 1));

  // first beat goes to the critical slot, later ones follow the wrapping index
  assign slot_sel = (state == S_WAIT) ? ofs_q : slot_idx;
  assign idx_inc  = {1'b0, slot_sel} + IW'(1);
  assign slot_nxt = (idx_inc >= IW'(W)) ? OFS_W'(idx_inc - IW'(W)) : idx_inc[OFS_W-1:0];

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (req_fire) state_n = S_REQ;
      S_REQ:  if (mreq_fire) state_n = S_WAIT;
      S_WAIT: begin
        if (beat_fire)    state_n = S_RECV;
        else if (tmo_hit) state_n = (retry == RW'(MAX_RETRIES)) ? S_IDLE : S_REQ;
      end
      S_RECV: if (beat_fire && last_beat) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      ofs_q      <= '0;
      slot_idx   <= '0;
      cnt        <= '0;
      timer      <= '0;
      retry      <= '0;
      crit_q     <= '0;
      crit_pulse <= 1'b0;
      err_pulse  <= 1'b0;
    end else if (!bus.i_halt) begin
      state      <= state_n;
      crit_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      case (state)
        S_IDLE: if (req_fire) begin
          addr_q <= bus.i_req_addr;
          ofs_q  <= bus.i_req_ofs;
          cnt    <= '0;
          retry  <= '0;
          timer  <= '0;
        end
        S_REQ: if (mreq_fire) timer <= '0;
        S_WAIT: begin
          if (beat_fire) begin
            crit_q     <= bus.i_mem_data;
            crit_pulse <= 1'b1;
            cnt        <= CW'(1);
            slot_idx   <= slot_nxt;
          end else if (tmo_hit) begin
            if (retry == RW'(MAX_RETRIES)) err_pulse <= 1'b1;
            else                           retry     <= retry + RW'(1);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RECV: if (beat_fire) begin
          cnt      <= cnt + CW'(1);
          slot_idx <= slot_nxt;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < W; g++) begin : g_slot
    assign slot_we[g] = beat_fire && (slot_sel == OFS_W'(g));
    mbc_slot #(.DW(DW)) u_slot (
      .clk    (clk),
      .arst_n (arst_n),
      .we     (slot_we[g]),
      .d      (bus.i_mem_data),
      .q      (slot_q[g])
    );
  end
endmodule

// File: tb/tb_mem_burst_controller.sv
// Directed bench: default-width controller with a short timeout, plus a
// 64-bit / 4-word instance for the parameter sweep.
module tb_mem_burst_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_burst_controller_if #(.ADDR_WIDTH(8), .MEM_DATA_WIDTH(32), .WORDS_PER_BLOCK(10)) ia ();
  mem_burst_controller_if #(.ADDR_WIDTH(8), .MEM_DATA_WIDTH(64), .WORDS_PER_BLOCK(4))  ib ();

  mem_burst_controller #(.ADDR_WIDTH(8), .MEM_DATA_WIDTH(32), .WORDS_PER_BLOCK(10),
                         .TIMEOUT_CYCLES(8), .MAX_RETRIES(3)) dut_a (.clk(clk), .arst_n(rst_n), .bus(ia));
  mem_burst_controller #(.ADDR_WIDTH(8), .MEM_DATA_WIDTH(64), .WORDS_PER_BLOCK(4))
                         dut_b (.clk(clk), .arst_n(rst_n), .bus(ib));

  // per-burst observations, cycles counted from request acceptance (cycle 0)
  int          r_vld_cyc, r_nvld, r_crit_cyc, r_ncrit, r_nreq, r_req2_cyc, r_err_cyc, r_nerr, r_halt_rdy;
  logic [31:0] r_crit_val;
  logic [7:0]  r_addr;
  logic        r_rr_done, r_rr_err;

  task automatic idle_inputs();
    ia.i_halt = 0; ia.i_req_valid = 0; ia.i_req_addr = '0; ia.i_req_ofs = '0;
    ia.i_mem_req_ready = 0; ia.i_mem_data = '0; ia.i_mem_data_valid = 0;
    ib.i_halt = 0; ib.i_req_valid = 0; ib.i_req_addr = '0; ib.i_req_ofs = '0;
    ib.i_mem_req_ready = 0; ib.i_mem_data = '0; ib.i_mem_data_valid = 0;
  endtask

  function automatic logic [319:0] exp_block(input int ofs, input logic [31:0] base);
    logic [319:0] e;
    e = '0;
    for (int k = 0; k < 10; k++) e[((ofs + k) % 10) * 32 +: 32] = base + 32'(k);
    return e;
  endfunction

  // Drives one request on dut_a; beats base+k offered from beat_start while k<10;
  // halt held for halt_len cycles once halt_after beats have been accepted.
  task automatic run_a(input logic [7:0] addr, input logic [3:0] ofs, input logic [31:0] base,
                       input int beat_start, input int halt_after, input int halt_len, input int ncyc);
    int k, hcnt;
    logic halting, acc;
    k = 0; hcnt = 0;
    r_vld_cyc = -1; r_nvld = 0; r_crit_cyc = -1; r_ncrit = 0; r_nreq = 0; r_req2_cyc = -1;
    r_err_cyc = -1; r_nerr = 0; r_halt_rdy = 0; r_crit_val = '0; r_addr = '0; r_rr_done = 1'bx; r_rr_err = 1'bx;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      halting = (k == halt_after) && (hcnt < halt_len);
      ia.i_halt = halting;
      ia.i_req_valid = (cyc == 0);
      ia.i_req_addr = addr; ia.i_req_ofs = ofs;
      ia.i_mem_req_ready = 1'b1;
      ia.i_mem_data_valid = (beat_start >= 0) && (cyc >= beat_start) && (k < 10);
      ia.i_mem_data = base + 32'(k);
      @(negedge clk);
      acc = ia.i_mem_data_valid && ia.o_mem_ready;
      if (halting && ia.o_mem_ready) r_halt_rdy++;
      if (ia.o_mem_req_valid) begin r_nreq++; if (r_nreq == 2) r_req2_cyc = cyc; end
      if (ia.o_crit_word_valid) begin r_ncrit++; r_crit_val = ia.o_crit_word; if (r_crit_cyc < 0) r_crit_cyc = cyc; end
      if (ia.o_block_data_valid) begin
        r_nvld++;
        if (r_vld_cyc < 0) begin r_vld_cyc = cyc; r_addr = ia.o_block_addr; r_rr_done = ia.o_req_ready; end
      end
      if (ia.o_error) begin r_nerr++; r_err_cyc = cyc; r_rr_err = ia.o_req_ready; end
      @(posedge clk); #1;
      if (halting) hcnt++;
      else if (acc) k++;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ia.o_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got %0b exp 1", ia.o_req_ready); end
    checks++; if (ia.o_mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid got %0b exp 0", ia.o_mem_req_valid); end
    checks++; if (ia.o_block_data !== '0) begin failures++; $display("FAIL reset_block_data got %0h exp 0", ia.o_block_data); end
    checks++; if ({ia.o_crit_word_valid, ia.o_block_data_valid, ia.o_error, ia.o_mem_ready} !== 4'b0)
      begin failures++; $display("FAIL reset_pulses got %b exp 0000", {ia.o_crit_word_valid, ia.o_block_data_valid, ia.o_error, ia.o_mem_ready}); end
    checks++; if (ib.o_block_data !== '0) begin failures++; $display("FAIL reset_b_block got %0h exp 0", ib.o_block_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_defaults();
    run_a(8'h5A, 4'd0, 32'h100, 1, -1, 0, 16);
    checks++; if (r_crit_val !== 32'h100) begin failures++; $display("FAIL def_crit got %0h exp 100", r_crit_val); end
    checks++; if (r_crit_cyc !== 3 || r_ncrit !== 1) begin failures++; $display("FAIL def_crit_pulse got cyc %0d n %0d exp cyc 3 n 1", r_crit_cyc, r_ncrit); end
    checks++; if (r_vld_cyc !== 12 || r_nvld !== 1) begin failures++; $display("FAIL def_valid got cyc %0d n %0d exp cyc 12 n 1", r_vld_cyc, r_nvld); end
    checks++; if (r_addr !== 8'h5A) begin failures++; $display("FAIL def_addr got %0h exp 5a", r_addr); end
    checks++; if (ia.o_block_data[31:0] !== 32'h100) begin failures++; $display("FAIL def_slot0 got %0h exp 100", ia.o_block_data[31:0]); end
    checks++; if (ia.o_block_data[319:288] !== 32'h109) begin failures++; $display("FAIL def_slot9 got %0h exp 109", ia.o_block_data[319:288]); end
    checks++; if (ia.o_block_data !== exp_block(0, 32'h100)) begin failures++; $display("FAIL def_block got %0h exp %0h", ia.o_block_data, exp_block(0, 32'h100)); end
  endtask

  task automatic test_wrap();
    run_a(8'h3C, 4'd3, 32'hA0, 2, -1, 0, 16);
    checks++; if (r_crit_val !== 32'hA0) begin failures++; $display("FAIL wrap_crit got %0h exp a0", r_crit_val); end
    checks++; if (ia.o_block_data[127:96] !== 32'hA0) begin failures++; $display("FAIL wrap_slot3 got %0h exp a0", ia.o_block_data[127:96]); end
    checks++; if (ia.o_block_data[31:0] !== 32'hA7) begin failures++; $display("FAIL wrap_slot0 got %0h exp a7", ia.o_block_data[31:0]); end
    checks++; if (ia.o_block_data !== exp_block(3, 32'hA0)) begin failures++; $display("FAIL wrap_block got %0h exp %0h", ia.o_block_data, exp_block(3, 32'hA0)); end
  endtask

  task automatic test_timeout();
    run_a(8'h77, 4'd1, 32'h0, -1, -1, 0, 42);
    checks++; if (r_nreq !== 4 || r_req2_cyc !== 10) begin failures++; $display("FAIL tmo_reissue got n %0d second %0d exp n 4 second 10", r_nreq, r_req2_cyc); end
    checks++; if (r_nerr !== 1 || r_err_cyc !== 37) begin failures++; $display("FAIL tmo_error got n %0d cyc %0d exp n 1 cyc 37", r_nerr, r_err_cyc); end
    checks++; if (r_rr_err !== 1'b1) begin failures++; $display("FAIL tmo_idle got %0b exp 1", r_rr_err); end
    checks++; if (r_nvld !== 0 || r_ncrit !== 0) begin failures++; $display("FAIL tmo_no_block got vld %0d crit %0d exp 0 0", r_nvld, r_ncrit); end
    // beat lands on the last WAIT cycle of the second retry
    run_a(8'h78, 4'd5, 32'h300, 27, -1, 0, 42);
    checks++; if (r_vld_cyc !== 37 || r_nvld !== 1) begin failures++; $display("FAIL tmo_recover_valid got cyc %0d n %0d exp 37 1", r_vld_cyc, r_nvld); end
    checks++; if (r_nerr !== 0 || r_nreq !== 3) begin failures++; $display("FAIL tmo_recover_err got err %0d req %0d exp 0 3", r_nerr, r_nreq); end
    checks++; if (ia.o_block_data !== exp_block(5, 32'h300)) begin failures++; $display("FAIL tmo_recover_block got %0h exp %0h", ia.o_block_data, exp_block(5, 32'h300)); end
  endtask

  task automatic test_halt();
    run_a(8'h5A, 4'd0, 32'h100, 2, 4, 5, 22);
    checks++; if (r_vld_cyc !== 17 || r_nvld !== 1) begin failures++; $display("FAIL halt_valid got cyc %0d n %0d exp 17 1", r_vld_cyc, r_nvld); end
    checks++; if (r_halt_rdy !== 0) begin failures++; $display("FAIL halt_mem_ready got %0d exp 0", r_halt_rdy); end
    checks++; if (ia.o_block_data !== exp_block(0, 32'h100)) begin failures++; $display("FAIL halt_block got %0h exp %0h", ia.o_block_data, exp_block(0, 32'h100)); end
    // halt across the critical-word pulse defers it
    run_a(8'h42, 4'd8, 32'h500, 2, 1, 2, 18);
    checks++; if (r_crit_cyc !== 5 || r_ncrit !== 1) begin failures++; $display("FAIL halt_crit_defer got cyc %0d n %0d exp 5 1", r_crit_cyc, r_ncrit); end
    checks++; if (r_vld_cyc !== 14) begin failures++; $display("FAIL halt_crit_valid got cyc %0d exp 14", r_vld_cyc); end
  endtask

  task automatic test_reset_mid();
    run_a(8'h11, 4'd2, 32'hB0, 2, -1, 0, 9);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ia.o_block_data !== '0 || ia.o_crit_word !== '0) begin failures++; $display("FAIL rstmid_data got blk %0h crit %0h exp 0", ia.o_block_data, ia.o_crit_word); end
    checks++; if (ia.o_block_addr !== '0 || ia.o_mem_req_addr !== '0) begin failures++; $display("FAIL rstmid_addr got %0h exp 0", ia.o_block_addr); end
    checks++; if (ia.o_req_ready !== 1'b1 || ia.o_mem_ready !== 1'b0) begin failures++; $display("FAIL rstmid_state got rr %0b mr %0b exp 1 0", ia.o_req_ready, ia.o_mem_ready); end
    @(posedge clk); #1;
    run_a(8'h22, 4'd7, 32'hC0, 2, -1, 0, 16);
    checks++; if (r_vld_cyc !== 12 || r_addr !== 8'h22) begin failures++; $display("FAIL rstmid_new got cyc %0d addr %0h exp 12 22", r_vld_cyc, r_addr); end
    checks++; if (ia.o_block_data !== exp_block(7, 32'hC0)) begin failures++; $display("FAIL rstmid_block got %0h exp %0h", ia.o_block_data, exp_block(7, 32'hC0)); end
  endtask

  task automatic test_back_to_back();
    run_a(8'h01, 4'd9, 32'hD0, 2, -1, 0, 13);
    checks++; if (r_rr_done !== 1'b0) begin failures++; $display("FAIL b2b_done_ready got %0b exp 0", r_rr_done); end
    run_a(8'h02, 4'd4, 32'hE0, 2, -1, 0, 13);
    checks++; if (r_vld_cyc !== 12 || r_addr !== 8'h02) begin failures++; $display("FAIL b2b_second got cyc %0d addr %0h exp 12 02", r_vld_cyc, r_addr); end
    checks++; if (ia.o_block_data !== exp_block(4, 32'hE0)) begin failures++; $display("FAIL b2b_block got %0h exp %0h", ia.o_block_data, exp_block(4, 32'hE0)); end
  endtask

  task automatic test_param_sweep();
    int k, vcyc;
    logic acc;
    k = 0; vcyc = -1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      ib.i_req_valid = (cyc == 0); ib.i_req_addr = 8'h33; ib.i_req_ofs = 2'd3;
      ib.i_mem_req_ready = 1'b1;
      ib.i_mem_data_valid = (cyc >= 2) && (k < 4);
      ib.i_mem_data = 64'hDEAD_0000_0000_0000 | 64'(k);
      @(negedge clk);
      acc = ib.i_mem_data_valid && ib.o_mem_ready;
      if (ib.o_block_data_valid && vcyc < 0) vcyc = cyc;
      @(posedge clk); #1;
      if (acc) k++;
    end
    idle_inputs();
    checks++; if (vcyc !== 6) begin failures++; $display("FAIL sweep_valid got cyc %0d exp 6", vcyc); end
    checks++; if (ib.o_block_data[255:192] !== 64'hDEAD_0000_0000_0000) begin failures++; $display("FAIL sweep_slot3 got %0h", ib.o_block_data[255:192]); end
    checks++; if (ib.o_block_data[63:0] !== 64'hDEAD_0000_0000_0001) begin failures++; $display("FAIL sweep_slot0 got %0h", ib.o_block_data[63:0]); end
    checks++; if (ib.o_block_data[191:64] !== {64'hDEAD_0000_0000_0003, 64'hDEAD_0000_0000_0002})
      begin failures++; $display("FAIL sweep_slot12 got %0h", ib.o_block_data[191:64]); end
    checks++; if (ib.o_crit_word !== 64'hDEAD_0000_0000_0000) begin failures++; $display("FAIL sweep_crit got %0h", ib.o_crit_word); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_defaults();
    test_wrap();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_back_to_back();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
